// File: rtl/mips_if_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package mips_if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        KILL  = 2'b10
    } fetch_state_t;

    localparam int unsigned INS_W   = 32;
    localparam int unsigned PC_INC  = 4;
    localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Three saturating event counters for the fetch stage (used when FETCH_PERF_CNT_EN is defined).
module if_perf_cnt
    import mips_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_evt,
    input  logic        stall_evt,
    input  logic        kill_evt,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_kill
);

    logic [31:0] fetch_cnt_r;
    logic [31:0] stall_cnt_r;
    logic [31:0] kill_cnt_r;

    // Counter registers, each holding at all-ones once saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
            kill_cnt_r  <= 32'd0;
        end else begin
            if (fetch_evt) fetch_cnt_r <= sat_inc(fetch_cnt_r);
            if (stall_evt) stall_cnt_r <= sat_inc(stall_cnt_r);
            if (kill_evt)  kill_cnt_r  <= sat_inc(kill_cnt_r);
        end
    end

    assign perf_fetch = fetch_cnt_r;
    assign perf_stall = stall_cnt_r;
    assign perf_kill  = kill_cnt_r;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, IMEM request handshake, IF/ID register, redirect/kill handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module if_fetch_ctrl
    import mips_if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_tgt,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_adr,
    input  logic              imem_rdy,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic              ifid_valid,
    input  logic              ifid_ready,
    output logic [INS_W-1:0]  ifid_ins,
    output logic [ADDR_W-1:0] ifid_npc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_kill
`endif
);

    fetch_state_t      state_r, state_nxt_s;
    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic [ADDR_W-1:0] tgt_q_r, tgt_q_nxt_s;
    logic              req_pending_r, req_pending_nxt_s;
    logic              ifid_valid_r, ifid_valid_nxt_s;
    logic [INS_W-1:0]  ifid_ins_r, ifid_ins_nxt_s;
    logic [ADDR_W-1:0] ifid_npc_r, ifid_npc_nxt_s;
    logic [ADDR_W-1:0] redir_tgt_s, pc_inc_s;
    logic              req_s, accept_s, discard_s;
    logic              unused_tgt_s;

    assign redir_tgt_s  = {branch_tgt[ADDR_W-1:2], 2'b00};
    assign pc_inc_s     = pc_r + ADDR_W'(PC_INC);
    assign unused_tgt_s = ^branch_tgt[1:0];

    // Next-state, PC and request decode
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        tgt_q_nxt_s = tgt_q_r;
        req_s       = 1'b0;
        accept_s    = 1'b0;
        discard_s   = 1'b0;
        case (state_r)
            IDLE: begin
                state_nxt_s = FETCH;
            end
            FETCH: begin
                req_s = (!halt && (!ifid_valid_r || ifid_ready)) || req_pending_r;
                if (pc_src) begin
                    // An outstanding request must finish at its old address before redirecting
                    if (req_s && !imem_rdy) begin
                        tgt_q_nxt_s = redir_tgt_s;
                        state_nxt_s = KILL;
                    end else begin
                        pc_nxt_s  = redir_tgt_s;
                        discard_s = req_s && imem_rdy;
                    end
                end else if (req_s && imem_rdy) begin
                    accept_s = 1'b1;
                    pc_nxt_s = pc_inc_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            KILL: begin
                req_s = 1'b1;
                if (imem_rdy) begin
                    discard_s   = 1'b1;
                    state_nxt_s = FETCH;
                    pc_nxt_s    = pc_src ? redir_tgt_s : tgt_q_r;
                end else if (pc_src) begin
                    tgt_q_nxt_s = redir_tgt_s;
                end else begin
                    tgt_q_nxt_s = tgt_q_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        req_pending_nxt_s = req_s && !imem_rdy;
    end

    // IF/ID output register next values: flush beats accept beats drain
    always_comb begin
        ifid_valid_nxt_s = ifid_valid_r;
        ifid_ins_nxt_s   = ifid_ins_r;
        ifid_npc_nxt_s   = ifid_npc_r;
        if (pc_src || (state_r == KILL)) begin
            ifid_valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            ifid_valid_nxt_s = 1'b1;
            ifid_ins_nxt_s   = imem_rdata;
            ifid_npc_nxt_s   = pc_inc_s;
        end else if (ifid_valid_r && ifid_ready) begin
            ifid_valid_nxt_s = 1'b0;
        end else begin
            ifid_valid_nxt_s = ifid_valid_r;
        end
    end

    // State, PC, redirect target and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            tgt_q_r       <= {ADDR_W{1'b0}};
            req_pending_r <= 1'b0;
            ifid_valid_r  <= 1'b0;
            ifid_ins_r    <= NOP_INS;
            ifid_npc_r    <= {ADDR_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            tgt_q_r       <= tgt_q_nxt_s;
            req_pending_r <= req_pending_nxt_s;
            ifid_valid_r  <= ifid_valid_nxt_s;
            ifid_ins_r    <= ifid_ins_nxt_s;
            ifid_npc_r    <= ifid_npc_nxt_s;
        end
    end

    assign imem_req   = req_s;
    assign imem_adr   = pc_r;
    assign ifid_valid = ifid_valid_r;
    assign ifid_ins   = ifid_ins_r;
    assign ifid_npc   = ifid_npc_r;

`ifdef FETCH_PERF_CNT_EN
    if_perf_cnt u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_evt  (ifid_valid_r && ifid_ready),
        .stall_evt  (ifid_valid_r && !ifid_ready),
        .kill_evt   (discard_s),
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall),
        .perf_kill  (perf_kill)
    );
`endif

endmodule
